// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants.
// Mode sets are localparams; helper sums the four segments of an axis.
package vga_timing_pkg;

  localparam int VGA640_H_VISIBLE = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_VISIBLE = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;

  localparam int TINY_H_VISIBLE = 8;
  localparam int TINY_H_FRONT   = 2;
  localparam int TINY_H_SYNC    = 2;
  localparam int TINY_H_BACK    = 2;
  localparam int TINY_V_VISIBLE = 4;
  localparam int TINY_V_FRONT   = 1;
  localparam int TINY_V_SYNC    = 1;
  localparam int TINY_V_BACK    = 1;

  function automatic int seg_total(
    input int vis,
    input int front,
    input int sync,
    input int back
  );
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MODULO up counter with combinational wrap flag.
// Ports: clk_25MHz, rst_n (sync, low), inc, count, wrap.
module mod_counter #(
  parameter int WIDTH  = 16,
  parameter int MODULO = 800
) (
  input  logic             clk_25MHz,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: linked H/V counters, sync/blank decode, strobes.
// In: clk_25MHz, rst_n, enable. Out: counts, syncs, video_on, pix_*, strobes, frame_count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA640_H_VISIBLE,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_VISIBLE = VGA640_V_VISIBLE,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CNT_W     = 16,
  parameter int FRAME_W   = 8
) (
  input  logic               clk_25MHz,
  input  logic               rst_n,
  input  logic               enable,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL =
    seg_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL =
    seg_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam longint CNT_SPAN = longint'(1) << CNT_W;

  generate
    if (longint'(H_TOTAL) > CNT_SPAN ||
        longint'(V_TOTAL) > CNT_SPAN) begin : g_cnt_w_chk
      $error("CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG =
    CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END =
    CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG =
    CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END =
    CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             hs_win;
  logic             vs_win;
  logic             vis_nxt;

  mod_counter #(
    .WIDTH  (CNT_W),
    .MODULO (H_TOTAL)
  ) u_h_cnt (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .inc       (enable),
    .count     (h_count),
    .wrap      (h_wrap)
  );

  mod_counter #(
    .WIDTH  (CNT_W),
    .MODULO (V_TOTAL)
  ) u_v_cnt (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .inc       (h_wrap),
    .count     (v_count),
    .wrap      (v_wrap)
  );

  // Mirror of what the counters will hold after this edge, so the
  // registered decode lines up with the registered counts.
  always_comb begin
    h_nxt = h_count;
    v_nxt = v_count;
    if (h_wrap) begin
      h_nxt = '0;
    end else if (enable) begin
      h_nxt = h_count + CNT_W'(1);
    end
    if (v_wrap) begin
      v_nxt = '0;
    end else if (h_wrap) begin
      v_nxt = v_count + CNT_W'(1);
    end
  end

  assign hs_win  = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
  assign vs_win  = (v_nxt >= VS_BEG) && (v_nxt < VS_END);
  assign vis_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);

  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= 1'b1;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hsync       <= hs_win ? HS_POL : ~HS_POL;
      vsync       <= vs_win ? VS_POL : ~VS_POL;
      video_on    <= vis_nxt;
      pix_x       <= vis_nxt ? h_nxt : '0;
      pix_y       <= vis_nxt ? v_nxt : '0;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) begin
        frame_count <= frame_count + FRAME_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: default mode and a tiny mode.
// Table vectors, hand sequences and a random run vs a raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic [15:0] px;
    logic [15:0] py;
    logic        hs;
    logic        vs;
    logic        vid;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } obs_t;

  typedef struct {
    bit r;
    bit e;
    int reps;
    int h;
    int v;
    bit hs;
    bit vs;
    bit vid;
    bit ls;
    bit fs;
    int fc;
  } vec_t;

  logic clk_25MHz = 1'b0;
  always #20 clk_25MHz = ~clk_25MHz;

  logic rst_d = 1'b0;
  logic en_d  = 1'b1;
  logic rst_s = 1'b0;
  logic en_s  = 1'b1;

  logic [15:0] d_h, d_v, d_px, d_py;
  logic        d_hs, d_vs, d_vid, d_ls, d_fs;
  logic [7:0]  d_fc;
  logic [15:0] s_h, s_v, s_px, s_py;
  logic        s_hs, s_vs, s_vid, s_ls, s_fs;
  logic [7:0]  s_fc;

  vga_timing_gen u_dflt (
    .clk_25MHz   (clk_25MHz),
    .rst_n       (rst_d),
    .enable      (en_d),
    .h_count     (d_h),
    .v_count     (d_v),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .video_on    (d_vid),
    .pix_x       (d_px),
    .pix_y       (d_py),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .frame_count (d_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .HS_POL (1'b1), .VS_POL (1'b0),
    .CNT_W (16), .FRAME_W (8)
  ) u_tiny (
    .clk_25MHz   (clk_25MHz),
    .rst_n       (rst_s),
    .enable      (en_s),
    .h_count     (s_h),
    .v_count     (s_v),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .video_on    (s_vid),
    .pix_x       (s_px),
    .pix_y       (s_py),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_count (s_fc)
  );

  obs_t od, os;
  assign od = {d_h, d_v, d_px, d_py, d_hs, d_vs, d_vid, d_ls, d_fs, d_fc};
  assign os = {s_h, s_v, s_px, s_py, s_hs, s_vs, s_vid, s_ls, s_fs, s_fc};

  int vectors = 0;
  int miscompares = 0;

  // Model state: enabled pixel ticks since reset, and whether the
  // last edge was an advancing one.
  longint n_d = 0;
  longint n_s = 0;
  bit     adv_d = 1'b0;
  bit     adv_s = 1'b0;

  always @(posedge clk_25MHz) begin
    if (!rst_d) begin
      n_d = 0;
      adv_d = 1'b0;
    end else begin
      adv_d = en_d;
      if (en_d) n_d = n_d + 1;
    end
    if (!rst_s) begin
      n_s = 0;
      adv_s = 1'b0;
    end else begin
      adv_s = en_s;
      if (en_s) n_s = n_s + 1;
    end
  end

  function automatic obs_t ref_model(
    input longint n, input bit adv,
    input int hv, input int hf, input int hw, input int hb,
    input int vv, input int vf, input int vw, input int vb,
    input bit hp, input bit vp
  );
    obs_t   o;
    longint ht, vt, h, ln, v, fr;
    ht = hv + hf + hw + hb;
    vt = vv + vf + vw + vb;
    h  = n % ht;
    ln = n / ht;
    v  = ln % vt;
    fr = ln / vt;
    o.h   = 16'(h);
    o.v   = 16'(v);
    o.vid = (h < hv) && (v < vv);
    o.px  = o.vid ? 16'(h) : 16'd0;
    o.py  = o.vid ? 16'(v) : 16'd0;
    o.hs  = (h >= hv + hf && h < hv + hf + hw) ? hp : !hp;
    o.vs  = (v >= vv + vf && v < vv + vf + vw) ? vp : !vp;
    o.ls  = adv && (h == 0);
    o.fs  = adv && (h == 0) && (v == 0);
    o.fc  = 8'(fr % 256);
    return o;
  endfunction

  function automatic obs_t exp_d();
    return ref_model(n_d, adv_d, 640, 16, 96, 48, 480, 10, 2, 33,
                     1'b0, 1'b0);
  endfunction

  function automatic obs_t exp_s();
    return ref_model(n_s, adv_s, 8, 2, 2, 2, 4, 1, 1, 1,
                     1'b1, 1'b0);
  endfunction

  task automatic check(input string nm, input obs_t got,
                       input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got h=%0d v=%0d (%h) expected h=%0d v=%0d (%h)",
               nm, got.h, got.v, got, exp.h, exp.v, exp);
    end
  endtask

  // One clock for the selected DUT; optional model comparison.
  task automatic step(input bit sel, input bit r, input bit e,
                      input bit chk);
    if (sel) begin
      rst_s = r;
      en_s  = e;
    end else begin
      rst_d = r;
      en_d  = e;
    end
    @(posedge clk_25MHz);
    @(negedge clk_25MHz);
    if (chk) begin
      if (sel) check("tiny_model", os, exp_s());
      else     check("dflt_model", od, exp_d());
    end
  endtask

  function automatic obs_t mk(input int h, input int v, input bit hs,
                              input bit vs, input bit vid, input bit ls,
                              input bit fs, input int fc);
    obs_t o;
    o.h   = 16'(h);
    o.v   = 16'(v);
    o.vid = vid;
    o.px  = vid ? 16'(h) : 16'd0;
    o.py  = vid ? 16'(v) : 16'd0;
    o.hs  = hs;
    o.vs  = vs;
    o.ls  = ls;
    o.fs  = fs;
    o.fc  = 8'(fc);
    return o;
  endfunction

  vec_t tbl[14];

  initial begin
    // Tiny mode: hsync active-high on h=10..11, vsync low on v=5.
    tbl[0]  = '{0, 1, 3,  0, 0, 0, 1, 1, 0, 0, 0};
    tbl[1]  = '{1, 1, 1,  1, 0, 0, 1, 1, 0, 0, 0};
    tbl[2]  = '{1, 0, 2,  1, 0, 0, 1, 1, 0, 0, 0};
    tbl[3]  = '{1, 1, 7,  8, 0, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 2, 10, 0, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 11, 0, 1, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 1, 12, 0, 0, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 1, 13, 0, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 1,  0, 1, 0, 1, 1, 1, 0, 0};
    tbl[9]  = '{1, 0, 1,  0, 1, 0, 1, 1, 0, 0, 0};
    tbl[10] = '{1, 1, 1,  1, 1, 0, 1, 1, 0, 0, 0};
    tbl[11] = '{1, 1, 55, 0, 5, 0, 0, 0, 1, 0, 0};
    tbl[12] = '{1, 1, 28, 0, 0, 0, 1, 1, 1, 1, 1};
    tbl[13] = '{0, 1, 1,  0, 0, 0, 1, 1, 0, 0, 0};

    @(negedge clk_25MHz);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        step(1'b1, tbl[i].r, tbl[i].e, 1'b0);
      end
      check($sformatf("tiny_tbl%0d", i), os,
            mk(tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs,
               tbl[i].vid, tbl[i].ls, tbl[i].fs, tbl[i].fc));
    end

    // Default mode: reset with enable high for three clocks.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("dflt_reset", od, mk(0, 0, 1, 1, 1, 0, 0, 0));

    // First line, then the 799 -> 0 wrap into line 1.
    for (int k = 0; k < 799; k++) step(1'b0, 1'b1, 1'b1, 1'b1);
    check("dflt_h799", od, mk(799, 0, 1, 1, 0, 0, 0, 0));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("dflt_line_wrap", od, mk(0, 1, 1, 1, 1, 1, 0, 0));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("dflt_strobe_1cyc", od, mk(1, 1, 1, 1, 1, 0, 0, 0));

    // Run to (300,2), then reset mid-frame.
    while (n_d < 1900) step(1'b0, 1'b1, 1'b1, 1'b1);
    check("dflt_at_300_2", od, mk(300, 2, 1, 1, 1, 0, 0, 0));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("dflt_mid_reset", od, mk(0, 0, 1, 1, 1, 0, 0, 0));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("dflt_after_rst", od, mk(1, 0, 1, 1, 1, 0, 0, 0));

    // Enable toggling every cycle across a line wrap.
    for (int k = 0; k < 1700; k++) begin
      step(1'b0, 1'b1, k[0] == 1'b0, 1'b1);
    end

    // Random enable with rare resets.
    for (int k = 0; k < 3000; k++) begin
      step(1'b0, $urandom_range(0, 499) != 0,
           $urandom_range(0, 3) != 0, 1'b1);
    end

    // Tiny mode random run.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2500; k++) begin
      step(1'b1, $urandom_range(0, 299) != 0,
           $urandom_range(0, 2) != 0, 1'b1);
    end

    // Tiny mode: 256 whole frames wraps the frame counter to 0.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 256 * 98; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
    end
    check("tiny_fc_wrap", os, mk(0, 0, 0, 1, 1, 1, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
